frame_rr_scheduler: RTL and testbench
=====================================

Name: frame_rr_scheduler

Overview:
- Frame-aware round-robin read scheduler for two channel FIFOs feeding one output stream in the readout path.
- Grants one channel at a time and holds the grant from header word to footer word, so frames from the two channels are never interleaved.
- Discards junk words that arrive ahead of a header.
- Closes runaway frames with a synthesized footer and keeps error counters.

Parameters:
- DATA_WIDTH, 64, word width.
- ID_WIDTH, 8, width of the frame-ID field at DIN[DATA_WIDTH-1 -: ID_WIDTH].
- HEADER_ID, 8'hAA, ID value that marks a header word.
- FOOTER_ID, 8'h55, ID value that marks a footer word.
- MAX_FRAME_LEN, 256, maximum output words per frame, including header and footer; must be at least 3.
- CNT_WIDTH, 16, width of the error counters.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous reset, active-low.
- CH0_DIN  in  DATA_WIDTH  head word of the ch0 FIFO (FWFT); valid when CH0_EMPTY=0.
- CH0_EMPTY  in  1  ch0 FIFO empty.
- CH0_READ_REQUEST  in  1  ch0 is requesting service.
- CH0_RE  out  1  pop ch0 head word (combinational).
- CH1_DIN, CH1_EMPTY, CH1_READ_REQUEST, CH1_RE: same as the ch0 ports, for channel 1.
- iREADY  in  1  downstream can accept a word next cycle.
- DOUT  out  DATA_WIDTH  output word (registered).
- oVALID  out  1  DOUT valid (registered).
- CUR_CH  out  1  currently or last granted channel.
- BUSY  out  1  state is not IDLE.
- DROP_CNT  out  CNT_WIDTH  count of words discarded before a header.
- ABORT_CNT  out  CNT_WIDTH  count of frames force-closed.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, oVALID=0, DOUT=0, CUR_CH=1 (so ch0 wins the first tie).
  - word_cnt=0, DROP_CNT=0, ABORT_CNT=0.
  - CHx_RE=0 while in reset.
  - Reset mid-frame abandons the frame with no footer emitted.
- Eligibility: elig_x = CHx_READ_REQUEST & ~CHx_EMPTY.
- State IDLE (no pops, oVALID<=0):
  - Only one channel eligible: grant it.
  - Both eligible: grant ~CUR_CH (round-robin).
  - On a grant: CUR_CH<=sel, word_cnt<=0, go to XFER next cycle.
  - Arbitration costs exactly one cycle per frame.
- State XFER, sel=CUR_CH, head=CHsel_DIN:
  - CHsel_EMPTY=1: no pop, oVALID<=0, hold state.
  - Hunting for header (word_cnt=0) and head ID != HEADER_ID: CHsel_RE=1 regardless of iREADY; word is not output; DROP_CNT+1.
  - Otherwise pop only when iREADY=1: CHsel_RE=1, DOUT<=head, oVALID<=1, word_cnt+1.
  - Popped word with word_cnt>=1 and ID==FOOTER_ID: next state IDLE.
  - word_cnt == MAX_FRAME_LEN-1 and head ID != FOOTER_ID: no pop; go to ABORT.
  - A header ID in mid-frame is treated as ordinary data.
  - iREADY=0: no pop, oVALID<=0.
- State ABORT:
  - When iREADY=1: DOUT<={FOOTER_ID, all-ones}, oVALID<=1, ABORT_CNT+1, next state IDLE.
  - The channel FIFO is not popped; the orphaned remainder is dropped later by the header hunt.
- CHx_RE is never asserted for the non-granted channel or when CHx_EMPTY=1.
- Latency: one cycle from CHsel_RE to oVALID/DOUT.
- Flow control: iREADY is a registered almost-full flag. The downstream absorbs at most one word after iREADY falls, so no skid buffer is used.
- Counters saturate at all-ones and do not wrap.
- CHx_READ_REQUEST is sampled only in IDLE. Deassertion mid-frame does not end the grant.
- Simultaneous requests: alternate strictly per frame, never per word.
- BUSY = (state != IDLE).

Test Plan:
- ch0 holds frame {AA..01, 00..02, 55..03}, REQ0=1, iREADY=1 -> CUR_CH=0; DOUT 3 consecutive words AA..01, 00..02, 55..03; BUSY falls the cycle after the footer is popped; DROP_CNT=0.
- Both channels hold 2 frames of 4 words each, both REQ=1 -> output frame order ch0, ch1, ch0, ch1; no interleaving; exactly 1 idle cycle between frames.
- ch1 head has 2 junk words (ID 8'h12) before a header -> 2 pops with oVALID=0; DROP_CNT=2; frame then output intact.
- MAX_FRAME_LEN=8, ch0 frame with no footer and 20 words queued -> 7 words out, then {8'h55, all-ones}; ABORT_CNT=1; FIFO not popped during ABORT; remaining words later dropped as junk.
- iREADY toggled 1,0,0,1 during a frame -> pops occur only in iREADY=1 cycles; no word lost or duplicated; oVALID=0 on the stall cycles.
- RESET asserted asynchronously mid-frame -> oVALID=0 and CHx_RE=0 immediately; after release, state=IDLE, counters=0, ch0 wins the first tie.

Source files
------------

// File: rtl/frame_rr_scheduler.sv
// Frame-aware round-robin reader for two FWFT channel FIFOs into one stream.
// A grant is held from header to footer; runaway frames get a synthesized footer.
module frame_rr_scheduler #(
  parameter int                DATA_WIDTH    = 64,
  parameter int                ID_WIDTH      = 8,
  parameter logic [ID_WIDTH-1:0] HEADER_ID   = 8'hAA,
  parameter logic [ID_WIDTH-1:0] FOOTER_ID   = 8'h55,
  parameter int                MAX_FRAME_LEN = 256,
  parameter int                CNT_WIDTH     = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] CH0_DIN,
  input  logic                  CH0_EMPTY,
  input  logic                  CH0_READ_REQUEST,
  output logic                  CH0_RE,
  input  logic [DATA_WIDTH-1:0] CH1_DIN,
  input  logic                  CH1_EMPTY,
  input  logic                  CH1_READ_REQUEST,
  output logic                  CH1_RE,
  input  logic                  iREADY,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  oVALID,
  output logic                  CUR_CH,
  output logic                  BUSY,
  output logic [CNT_WIDTH-1:0]  DROP_CNT,
  output logic [CNT_WIDTH-1:0]  ABORT_CNT
);

  localparam int WC_W = $clog2(MAX_FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

  state_t                 state_reg, state_next;
  logic                   cur_ch_reg, cur_ch_next;
  logic [WC_W-1:0]        word_cnt_reg, word_cnt_next;
  logic [DATA_WIDTH-1:0]  dout_reg, dout_next;
  logic                   valid_reg, valid_next;
  logic [CNT_WIDTH-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [CNT_WIDTH-1:0]   abort_cnt_reg, abort_cnt_next;
  logic                   pop;

  logic [1:0][DATA_WIDTH-1:0] din;
  logic [1:0]                 empty;
  logic [1:0]                 req;
  logic [1:0]                 elig;
  logic [1:0]                 re;
  logic [DATA_WIDTH-1:0]      head;
  logic [ID_WIDTH-1:0]        head_id;

  assign din   = {CH1_DIN, CH0_DIN};
  assign empty = {CH1_EMPTY, CH0_EMPTY};
  assign req   = {CH1_READ_REQUEST, CH0_READ_REQUEST};

  // Pop strobes are gated by reset so they drop the instant RESET falls.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      assign elig[gi] = req[gi] & ~empty[gi];
      assign re[gi]   = pop & (cur_ch_reg == 1'(gi)) & ~empty[gi] & RESET;
    end
  endgenerate

  assign CH0_RE  = re[0];
  assign CH1_RE  = re[1];
  assign head    = din[cur_ch_reg];
  assign head_id = head[DATA_WIDTH-1 -: ID_WIDTH];

  always_comb begin
    state_next     = state_reg;
    cur_ch_next    = cur_ch_reg;
    word_cnt_next  = word_cnt_reg;
    dout_next      = dout_reg;
    valid_next     = 1'b0;
    drop_cnt_next  = drop_cnt_reg;
    abort_cnt_next = abort_cnt_reg;
    pop            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (elig != 2'b00) begin
          cur_ch_next   = (elig == 2'b11) ? ~cur_ch_reg : elig[1];
          word_cnt_next = '0;
          state_next    = XFER;
        end
      end
      XFER: begin
        if (!empty[cur_ch_reg]) begin
          if (word_cnt_reg == '0 && head_id != HEADER_ID) begin
            // Junk ahead of a header is drained without waiting on downstream.
            pop = 1'b1;
            if (!(&drop_cnt_reg)) drop_cnt_next = drop_cnt_reg + CNT_WIDTH'(1);
          end else if (word_cnt_reg == WC_W'(MAX_FRAME_LEN - 1) && head_id != FOOTER_ID) begin
            state_next = ABORT;
          end else if (iREADY) begin
            pop           = 1'b1;
            dout_next     = head;
            valid_next    = 1'b1;
            word_cnt_next = word_cnt_reg + WC_W'(1);
            if (word_cnt_reg != '0 && head_id == FOOTER_ID) state_next = IDLE;
          end
        end
      end
      ABORT: begin
        if (iREADY) begin
          dout_next  = {FOOTER_ID, {(DATA_WIDTH - ID_WIDTH){1'b1}}};
          valid_next = 1'b1;
          if (!(&abort_cnt_reg)) abort_cnt_next = abort_cnt_reg + CNT_WIDTH'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      cur_ch_reg    <= 1'b1;
      word_cnt_reg  <= '0;
      dout_reg      <= '0;
      valid_reg     <= 1'b0;
      drop_cnt_reg  <= '0;
      abort_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cur_ch_reg    <= cur_ch_next;
      word_cnt_reg  <= word_cnt_next;
      dout_reg      <= dout_next;
      valid_reg     <= valid_next;
      drop_cnt_reg  <= drop_cnt_next;
      abort_cnt_reg <= abort_cnt_next;
    end
  end

  assign DOUT      = dout_reg;
  assign oVALID    = valid_reg;
  assign CUR_CH    = cur_ch_reg;
  assign BUSY      = (state_reg != IDLE);
  assign DROP_CNT  = drop_cnt_reg;
  assign ABORT_CNT = abort_cnt_reg;

endmodule

// File: tb/tb_frame_rr_scheduler.sv
// Directed bench for frame_rr_scheduler: FWFT FIFO models feed the DUT and a
// monitor pops hand-written expected words from a scoreboard queue.
module tb_frame_rr_scheduler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [63:0] CH0_DIN = '0, CH1_DIN = '0;
  logic        CH0_EMPTY = 1'b1, CH1_EMPTY = 1'b1;
  logic        CH0_READ_REQUEST = 1'b0, CH1_READ_REQUEST = 1'b0;
  logic        CH0_RE, CH1_RE;
  logic        iREADY = 1'b1;
  logic [63:0] DOUT;
  logic        oVALID, CUR_CH, BUSY;
  logic [15:0] DROP_CNT, ABORT_CNT;

  frame_rr_scheduler #(.MAX_FRAME_LEN(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .CH0_DIN(CH0_DIN), .CH0_EMPTY(CH0_EMPTY), .CH0_READ_REQUEST(CH0_READ_REQUEST), .CH0_RE(CH0_RE),
    .CH1_DIN(CH1_DIN), .CH1_EMPTY(CH1_EMPTY), .CH1_READ_REQUEST(CH1_READ_REQUEST), .CH1_RE(CH1_RE),
    .iREADY(iREADY), .DOUT(DOUT), .oVALID(oVALID), .CUR_CH(CUR_CH), .BUSY(BUSY),
    .DROP_CNT(DROP_CNT), .ABORT_CNT(ABORT_CNT)
  );

  always #5 CLK = ~CLK;

  logic [63:0] q0[$], q1[$], exp_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, first_v = -1, last_v = -1;
  bit stall_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] w(input logic [7:0] id, input logic [55:0] p);
    return {id, p};
  endfunction

  task automatic drive_fifos();
    CH0_EMPTY = (q0.size() == 0);
    CH1_EMPTY = (q1.size() == 0);
    CH0_DIN   = CH0_EMPTY ? 64'h0 : q0[0];
    CH1_DIN   = CH1_EMPTY ? 64'h0 : q1[0];
  endtask

  // FIFO model: pop strobes are sampled mid-cycle and applied after the edge.
  initial begin
    bit p0, p1;
    forever begin
      @(negedge CLK);
      drive_fifos();
      #1;
      p0 = CH0_RE;
      p1 = CH1_RE;
      if (p0 || p1) begin
        check("re_exclusive", {63'h0, p0 & p1}, 64'h0);
        check("re_granted_ch", {63'h0, CUR_CH}, {63'h0, p1});
        if (stall_chk) check("pop_only_when_ready", {63'h0, iREADY}, 64'h1);
      end
      @(posedge CLK);
      #1;
      if (RESET) begin
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
      end
      drive_fifos();
    end
  end

  // Monitor: every valid output word must match the next expected word.
  always @(negedge CLK) begin
    logic [63:0] e;
    cyc++;
    if (oVALID) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (exp_q.size() == 0) begin
        check("dout_unexpected", DOUT, 64'hx);
      end else begin
        e = exp_q.pop_front();
        check("dout", DOUT, e);
      end
      if (DOUT[63:56] == 8'h55) check("busy_after_footer", {63'h0, BUSY}, 64'h0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic push_frame(input bit ch, input logic [55:0] base, input int n);
    logic [63:0] word;
    for (int i = 0; i < n; i++) begin
      word = (i == 0) ? w(8'hAA, base) : (i == n - 1) ? w(8'h55, base + 56'(i)) : w(8'h00, base + 56'(i));
      if (ch) q1.push_back(word); else q0.push_back(word);
      exp_q.push_back(word);
    end
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge CLK);
    check("drain_timeout", 64'(exp_q.size()), 64'h0);
    tick(3);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [7:0] seq [9];
    // Reset state
    tick(2);
    check("rst_re0", {63'h0, CH0_RE}, 64'h0);
    check("rst_re1", {63'h0, CH1_RE}, 64'h0);
    RESET = 1'b1;
    tick(1);
    check("rst_ovalid", {63'h0, oVALID}, 64'h0);
    check("rst_dout", DOUT, 64'h0);
    check("rst_cur_ch", {63'h0, CUR_CH}, 64'h1);
    check("rst_busy", {63'h0, BUSY}, 64'h0);
    check("rst_drop", {48'h0, DROP_CNT}, 64'h0);
    check("rst_abort", {48'h0, ABORT_CNT}, 64'h0);

    // Single three-word frame on ch0
    push_frame(1'b0, 56'h1, 3);
    CH0_READ_REQUEST = 1'b1;
    wait_drain(50);
    check("t1_cur_ch", {63'h0, CUR_CH}, 64'h0);
    check("t1_busy", {63'h0, BUSY}, 64'h0);
    check("t1_drop", {48'h0, DROP_CNT}, 64'h0);
    CH0_READ_REQUEST = 1'b0;

    // Two frames per channel with both requesting: strict per-frame alternation
    do_reset();
    push_frame(1'b0, 56'h100, 4);
    push_frame(1'b1, 56'h200, 4);
    push_frame(1'b0, 56'h300, 4);
    push_frame(1'b1, 56'h400, 4);
    first_v = -1;
    CH0_READ_REQUEST = 1'b1;
    CH1_READ_REQUEST = 1'b1;
    wait_drain(100);
    check("t2_frame_spacing", 64'(last_v - first_v), 64'd18);
    check("t2_cur_ch", {63'h0, CUR_CH}, 64'h1);
    CH0_READ_REQUEST = 1'b0;

    // Two junk words ahead of a ch1 header
    q1.push_back(w(8'h12, 56'hdead0));
    q1.push_back(w(8'h12, 56'hdead1));
    push_frame(1'b1, 56'h500, 3);
    wait_drain(50);
    check("t3_drop", {48'h0, DROP_CNT}, 64'd2);
    check("t3_q1_empty", 64'(q1.size()), 64'h0);
    CH1_READ_REQUEST = 1'b0;

    // Runaway frame: header + 19 data words, no footer, MAX_FRAME_LEN=8
    q0.push_back(w(8'hAA, 56'h600));
    exp_q.push_back(w(8'hAA, 56'h600));
    for (int i = 1; i < 20; i++) begin
      q0.push_back(w(8'h00, 56'h600 + 56'(i)));
      if (i < 7) exp_q.push_back(w(8'h00, 56'h600 + 56'(i)));
    end
    exp_q.push_back(64'h55FF_FFFF_FFFF_FFFF);
    CH0_READ_REQUEST = 1'b1;
    wait_drain(80);
    for (int i = 0; i < 60 && q0.size() != 0; i++) tick(1);
    check("t4_q0_empty", 64'(q0.size()), 64'h0);
    check("t4_abort", {48'h0, ABORT_CNT}, 64'd1);
    check("t4_drop", {48'h0, DROP_CNT}, 64'd15);
    check("t4_busy_hunting", {63'h0, BUSY}, 64'h1);
    CH0_READ_REQUEST = 1'b0;

    // Downstream stalls mid-frame
    iREADY = 1'b0;
    push_frame(1'b0, 56'h700, 4);
    tick(3);
    check("t5_no_pop_stalled", 64'(q0.size()), 64'd4);
    stall_chk = 1'b1;
    seq = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
    foreach (seq[i]) begin
      iREADY = seq[i][0];
      @(posedge CLK);
      #1;
      if (seq[i] == 8'd0) check("t5_stall_ovalid", {63'h0, oVALID}, 64'h0);
      #1;
    end
    stall_chk = 1'b0;
    iREADY = 1'b1;
    wait_drain(30);
    check("t5_q0_empty", 64'(q0.size()), 64'h0);
    check("t5_drop", {48'h0, DROP_CNT}, 64'd15);

    // Asynchronous reset mid-frame
    push_frame(1'b0, 56'h800, 6);
    CH0_READ_REQUEST = 1'b1;
    for (int i = 0; i < 20 && !oVALID; i++) @(negedge CLK);
    check("t6_frame_started", {63'h0, oVALID}, 64'h1);
    @(negedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    check("t6_async_ovalid", {63'h0, oVALID}, 64'h0);
    check("t6_async_re0", {63'h0, CH0_RE}, 64'h0);
    check("t6_async_re1", {63'h0, CH1_RE}, 64'h0);
    exp_q.delete();
    q0.delete();
    q1.delete();
    CH0_READ_REQUEST = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(1);
    check("t6_busy", {63'h0, BUSY}, 64'h0);
    check("t6_dout", DOUT, 64'h0);
    check("t6_drop", {48'h0, DROP_CNT}, 64'h0);
    check("t6_abort", {48'h0, ABORT_CNT}, 64'h0);
    check("t6_cur_ch", {63'h0, CUR_CH}, 64'h1);
    push_frame(1'b0, 56'h900, 3);
    push_frame(1'b1, 56'hA00, 3);
    CH0_READ_REQUEST = 1'b1;
    CH1_READ_REQUEST = 1'b1;
    wait_drain(50);
    check("t6_cur_ch_end", {63'h0, CUR_CH}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
